// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, port identifiers
// and downstream operation codes.
package arb_structs;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FETCH = 2'd1,
    ARB_LDST  = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_LDST  = 1'b1
  } arb_port_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_e;

  // Bit positions inside the request/grant vectors handed to the chooser.
  localparam int GNT_FETCH = 0;
  localparam int GNT_LDST  = 1;

  localparam logic [3:0] BYTE_EN_WORD = 4'hF;

  // A simultaneous read+write from load/store is illegal; the write wins.
  function automatic arb_op_e ldst_op(input logic wr);
    arb_op_e op;
    if (wr) begin
      op = OP_WRITE;
    end else begin
      op = OP_READ;
    end
    return op;
  endfunction

  function automatic arb_port_e grant_to_port(input logic [1:0] grant);
    arb_port_e port;
    if (grant[GNT_LDST]) begin
      port = PORT_LDST;
    end else begin
      port = PORT_FETCH;
    end
    return port;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and downstream memory signals. The slave
// modport is the arbiter's view; master is the surrounding core/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              fetch_mem_read;
  logic [ADDR_W-1:0] fetch_mem_address;
  logic [DATA_W-1:0] fetch_mem_rdata;
  logic              fetch_mem_resp;

  logic              ld_st_mem_read;
  logic              ld_st_mem_write;
  logic [ADDR_W-1:0] ld_st_mem_address;
  logic [DATA_W-1:0] ld_st_mem_wdata;
  logic [DATA_W-1:0] ld_st_mem_rdata;
  logic              ld_st_mem_resp;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_byte_enable;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  fetch_mem_read,
    input  fetch_mem_address,
    output fetch_mem_rdata,
    output fetch_mem_resp,
    input  ld_st_mem_read,
    input  ld_st_mem_write,
    input  ld_st_mem_address,
    input  ld_st_mem_wdata,
    output ld_st_mem_rdata,
    output ld_st_mem_resp,
    output mem_read,
    output mem_write,
    output mem_address,
    output mem_wdata,
    output mem_byte_enable,
    input  mem_rdata,
    input  mem_resp
  );

  modport master (
    output fetch_mem_read,
    output fetch_mem_address,
    input  fetch_mem_rdata,
    input  fetch_mem_resp,
    output ld_st_mem_read,
    output ld_st_mem_write,
    output ld_st_mem_address,
    output ld_st_mem_wdata,
    input  ld_st_mem_rdata,
    input  ld_st_mem_resp,
    input  mem_read,
    input  mem_write,
    input  mem_address,
    input  mem_wdata,
    input  mem_byte_enable,
    output mem_rdata,
    output mem_resp
  );

endinterface

// File: rtl/mem_port_arbiter_rr2.sv
// Two-way round-robin chooser: a lone requester always wins, and under
// contention the port that was not granted last wins.
module arb_rr2
  import arb_structs::*;
(
  input  logic [1:0] req,
  input  arb_port_e  last,
  output logic [1:0] grant,
  output logic       valid
);

  // Pick one requester, favouring the port that lost the previous contention.
  always_comb begin
    grant = 2'b00;
    valid = 1'b0;
    case (req)
      2'b01: begin
        grant = 2'b01;
        valid = 1'b1;
      end
      2'b10: begin
        grant = 2'b10;
        valid = 1'b1;
      end
      2'b11: begin
        valid = 1'b1;
        if (last == PORT_FETCH) begin
          grant = 2'b10;
        end else begin
          grant = 2'b01;
        end
      end
      default: begin
        grant = 2'b00;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and load/store initiators onto one downstream memory
// port, registers the granted request and steers the response back.
module mem_port_arbiter
  import arb_structs::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  arb_state_e        state_r;
  arb_port_e         last_q;
  arb_op_e           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mem_read_r;
  logic              mem_write_r;

  logic [1:0]        req_s;
  logic [1:0]        grant_s;
  logic              grant_valid_s;
  logic              contention_s;
  arb_op_e           ldst_op_s;
  logic              fetch_resp_s;
  logic              ldst_resp_s;

  assign req_s[GNT_FETCH] = bus.fetch_mem_read;
  assign req_s[GNT_LDST]  = bus.ld_st_mem_read | bus.ld_st_mem_write;
  assign contention_s     = req_s[GNT_FETCH] & req_s[GNT_LDST];
  assign ldst_op_s        = ldst_op(bus.ld_st_mem_write);

  arb_rr2 u_rr2 (
    .req   (req_s),
    .last  (last_q),
    .grant (grant_s),
    .valid (grant_valid_s)
  );

  // Arbitration FSM together with the captured request and downstream strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ARB_IDLE;
      last_q      <= PORT_FETCH;
      op_q        <= OP_READ;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (grant_valid_s) begin
            if (grant_s[GNT_LDST]) begin
              state_r     <= ARB_LDST;
              addr_q      <= bus.ld_st_mem_address;
              wdata_q     <= bus.ld_st_mem_wdata;
              op_q        <= ldst_op_s;
              mem_read_r  <= (ldst_op_s == OP_READ);
              mem_write_r <= (ldst_op_s == OP_WRITE);
            end else begin
              state_r     <= ARB_FETCH;
              addr_q      <= bus.fetch_mem_address;
              op_q        <= OP_READ;
              mem_read_r  <= 1'b1;
              mem_write_r <= 1'b0;
            end
            // Only a contended grant moves the round-robin pointer.
            if (contention_s) begin
              last_q <= grant_to_port(grant_s);
            end else begin
              last_q <= last_q;
            end
          end else begin
            state_r <= ARB_IDLE;
          end
        end
        ARB_FETCH, ARB_LDST: begin
          if (bus.mem_resp) begin
            state_r     <= ARB_IDLE;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r     <= ARB_IDLE;
          mem_read_r  <= 1'b0;
          mem_write_r <= 1'b0;
        end
      endcase
    end
  end

  // Route the downstream completion to whichever port owns the transaction.
  always_comb begin
    fetch_resp_s = 1'b0;
    ldst_resp_s  = 1'b0;
    case (state_r)
      ARB_FETCH: begin
        fetch_resp_s = bus.mem_resp;
        ldst_resp_s  = 1'b0;
      end
      ARB_LDST: begin
        fetch_resp_s = 1'b0;
        ldst_resp_s  = bus.mem_resp;
      end
      default: begin
        fetch_resp_s = 1'b0;
        ldst_resp_s  = 1'b0;
      end
    endcase
  end

  assign bus.mem_read        = mem_read_r;
  assign bus.mem_write       = mem_write_r;
  assign bus.mem_address     = addr_q;
  assign bus.mem_wdata       = wdata_q;
  assign bus.mem_byte_enable = BYTE_EN_WORD;

  assign bus.fetch_mem_resp  = fetch_resp_s;
  assign bus.ld_st_mem_resp  = ldst_resp_s;
  assign bus.fetch_mem_rdata = bus.mem_rdata;
  assign bus.ld_st_mem_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_mem_port_arbiter;
  import arb_structs::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        f_rd;
    logic        l_rd;
    logic        l_wr;
    logic [31:0] f_addr;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    int          lat;
    logic [31:0] rdata;
    logic        exp_ldst;
    logic        exp_wr;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.fetch_mem_read    = 1'b0;
    bus.fetch_mem_address = 32'd0;
    bus.ld_st_mem_read    = 1'b0;
    bus.ld_st_mem_write   = 1'b0;
    bus.ld_st_mem_address = 32'd0;
    bus.ld_st_mem_wdata   = 32'd0;
    bus.mem_rdata         = 32'd0;
    bus.mem_resp          = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    step();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Runs one granted transaction starting from an idle cycle whose requests
  // are already driven; the memory answers lat cycles after the grant cycle.
  task automatic run_txn(input string tag, input logic exp_ldst, input logic exp_wr,
                         input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                         input int lat, input logic [31:0] rdata);
    step();
    #1;
    chk1({tag, ".grant_read"},  bus.mem_read,  !exp_wr);
    chk1({tag, ".grant_write"}, bus.mem_write, exp_wr);
    chk({tag, ".grant_addr"},   bus.mem_address, exp_addr);
    if (exp_wr) chk({tag, ".grant_wdata"}, bus.mem_wdata, exp_wdata);
    chk({tag, ".byte_en"}, {28'd0, bus.mem_byte_enable}, 32'h0000_000F);
    for (int k = 0; k < lat; k++) begin
      if (exp_ldst) begin
        bus.ld_st_mem_address = ~bus.ld_st_mem_address;
        bus.ld_st_mem_wdata   = bus.ld_st_mem_wdata ^ 32'hFFFF_0000;
      end else begin
        bus.fetch_mem_address = bus.fetch_mem_address + 32'd4;
      end
      step();
      #1;
      chk1({tag, ".hold_req"}, bus.mem_read | bus.mem_write, 1'b1);
      chk({tag, ".hold_addr"}, bus.mem_address, exp_addr);
      if (exp_wr) chk({tag, ".hold_wdata"}, bus.mem_wdata, exp_wdata);
      chk1({tag, ".early_resp"}, bus.fetch_mem_resp | bus.ld_st_mem_resp, 1'b0);
    end
    step();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = rdata;
    #1;
    chk1({tag, ".resp_read"},  bus.mem_read,  !exp_wr);
    chk1({tag, ".resp_write"}, bus.mem_write, exp_wr);
    chk1({tag, ".fetch_resp"}, bus.fetch_mem_resp, !exp_ldst);
    chk1({tag, ".ldst_resp"},  bus.ld_st_mem_resp, exp_ldst);
    chk({tag, ".fetch_rdata"}, bus.fetch_mem_rdata, rdata);
    chk({tag, ".ldst_rdata"},  bus.ld_st_mem_rdata, rdata);
    step();
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = ~rdata;
    if (exp_ldst) begin
      bus.ld_st_mem_read  = 1'b0;
      bus.ld_st_mem_write = 1'b0;
    end else begin
      bus.fetch_mem_read = 1'b0;
    end
    #1;
    chk1({tag, ".bubble_req"}, bus.mem_read | bus.mem_write, 1'b0);
  endtask

  vec_t vecs[6];

  initial begin
    arb_port_e   last_m;
    logic        f_pend;
    logic        l_pend;
    logic        l_wr_m;
    logic [31:0] f_addr_m;
    logic [31:0] l_addr_m;
    logic [31:0] l_wdata_m;
    logic        g_ldst;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0060, 32'h0, 32'h0, 2, 32'h0000_0013,
                1'b0, 1'b0, 32'h0000_0060, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0200, 32'h0, 0, 32'hCAFE_0001,
                1'b1, 1'b0, 32'h0000_0200, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0100, 32'hDEAD_BEEF, 2, 32'h0,
                1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0044, 32'h1234_5678, 1, 32'h0,
                1'b1, 1'b1, 32'h0000_0044, 32'h1234_5678};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h0000_0400, 32'h0, 1, 32'h0BAD_F00D,
                1'b1, 1'b0, 32'h0000_0400, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h0000_0084, 32'h0000_0408, 32'hA5A5_5A5A, 3, 32'h0,
                1'b1, 1'b1, 32'h0000_0408, 32'hA5A5_5A5A};

    // Reset values, with a stale memory response driven during reset.
    clear_inputs();
    #3;
    rst = 1'b0;
    bus.mem_resp = 1'b1;
    #1;
    chk1("rst.mem_read",   bus.mem_read,  1'b0);
    chk1("rst.mem_write",  bus.mem_write, 1'b0);
    chk("rst.mem_address", bus.mem_address, 32'h0);
    chk("rst.mem_wdata",   bus.mem_wdata,   32'h0);
    chk("rst.byte_en",     {28'd0, bus.mem_byte_enable}, 32'h0000_000F);
    chk1("rst.fetch_resp", bus.fetch_mem_resp, 1'b0);
    chk1("rst.ldst_resp",  bus.ld_st_mem_resp, 1'b0);
    step();
    rst = 1'b1;
    step();
    #1;
    chk1("idle_stale.fetch_resp", bus.fetch_mem_resp, 1'b0);
    chk1("idle_stale.ldst_resp",  bus.ld_st_mem_resp, 1'b0);
    chk1("idle_stale.mem_req",    bus.mem_read | bus.mem_write, 1'b0);
    bus.mem_resp = 1'b0;

    // Directed single-transaction table, each row from a fresh reset.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      bus.fetch_mem_read    = vecs[i].f_rd;
      bus.fetch_mem_address = vecs[i].f_addr;
      bus.ld_st_mem_read    = vecs[i].l_rd;
      bus.ld_st_mem_write   = vecs[i].l_wr;
      bus.ld_st_mem_address = vecs[i].l_addr;
      bus.ld_st_mem_wdata   = vecs[i].l_wdata;
      run_txn($sformatf("vec%0d", i), vecs[i].exp_ldst, vecs[i].exp_wr,
              vecs[i].exp_addr, vecs[i].exp_wdata, vecs[i].lat, vecs[i].rdata);
    end

    // Both ports requesting continuously: strict alternation starting with ld/st.
    do_reset();
    f_addr_m = 32'h0000_1000;
    l_addr_m = 32'h0000_2000;
    bus.fetch_mem_read    = 1'b1;
    bus.fetch_mem_address = f_addr_m;
    bus.ld_st_mem_read    = 1'b1;
    bus.ld_st_mem_address = l_addr_m;
    for (int i = 0; i < 6; i++) begin
      g_ldst = (i % 2 == 0);
      run_txn($sformatf("alt%0d", i), g_ldst, 1'b0, g_ldst ? l_addr_m : f_addr_m,
              32'h0, i % 3, 32'h5000_0000 + i);
      if (g_ldst) begin
        l_addr_m = l_addr_m + 32'h10;
        bus.ld_st_mem_read    = 1'b1;
        bus.ld_st_mem_address = l_addr_m;
      end else begin
        f_addr_m = f_addr_m + 32'h10;
        bus.fetch_mem_read    = 1'b1;
        bus.fetch_mem_address = f_addr_m;
      end
    end

    // Reset while a fetch is in flight; a late memory response must be dropped.
    do_reset();
    bus.fetch_mem_read    = 1'b1;
    bus.fetch_mem_address = 32'h0000_0500;
    step();
    #1;
    chk1("midrst.pre_read", bus.mem_read, 1'b1);
    rst = 1'b0;
    #1;
    chk1("midrst.read_drop", bus.mem_read, 1'b0);
    chk("midrst.addr_clear", bus.mem_address, 32'h0);
    bus.fetch_mem_read = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    bus.mem_resp = 1'b1;
    #1;
    chk1("midrst.fetch_resp", bus.fetch_mem_resp, 1'b0);
    chk1("midrst.ldst_resp",  bus.ld_st_mem_resp, 1'b0);
    chk1("midrst.mem_req",    bus.mem_read | bus.mem_write, 1'b0);
    step();
    bus.mem_resp          = 1'b0;
    bus.ld_st_mem_read    = 1'b1;
    bus.ld_st_mem_address = 32'h0000_0300;
    run_txn("midrst.next", 1'b1, 1'b0, 32'h0000_0300, 32'h0, 1, 32'h7777_0000);

    // Randomized traffic against a transaction-level grant model.
    do_reset();
    last_m    = PORT_FETCH;
    f_pend    = 1'b0;
    l_pend    = 1'b0;
    l_wr_m    = 1'b0;
    f_addr_m  = 32'h0;
    l_addr_m  = 32'h0;
    l_wdata_m = 32'h0;
    for (int n = 0; n < 60; n++) begin
      if (!f_pend && ($urandom_range(0, 1) == 1)) begin
        f_pend   = 1'b1;
        f_addr_m = $urandom;
        bus.fetch_mem_read    = 1'b1;
        bus.fetch_mem_address = f_addr_m;
      end
      if (!l_pend && ($urandom_range(0, 1) == 1)) begin
        l_pend    = 1'b1;
        l_wr_m    = ($urandom_range(0, 1) == 1);
        l_addr_m  = $urandom;
        l_wdata_m = $urandom;
        bus.ld_st_mem_write   = l_wr_m;
        bus.ld_st_mem_read    = l_wr_m ? ($urandom_range(0, 3) == 0) : 1'b1;
        bus.ld_st_mem_address = l_addr_m;
        bus.ld_st_mem_wdata   = l_wdata_m;
      end
      if (!f_pend && !l_pend) begin
        step();
        #1;
        chk1("rand.idle_req", bus.mem_read | bus.mem_write, 1'b0);
      end else begin
        if (f_pend && l_pend) begin
          g_ldst = (last_m == PORT_FETCH);
          last_m = g_ldst ? PORT_LDST : PORT_FETCH;
        end else begin
          g_ldst = l_pend;
        end
        run_txn($sformatf("rand%0d", n), g_ldst, g_ldst & l_wr_m,
                g_ldst ? l_addr_m : f_addr_m, l_wdata_m,
                $urandom_range(0, 3), $urandom);
        if (g_ldst) l_pend = 1'b0;
        else        f_pend = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
